// File: rtl/alu_multdiv_seq.sv
// Multicycle signed multiply/divide sequencer sharing one 32-bit add/sub alu.
// Multiply is unsigned shift-add on magnitudes, divide is restoring division;
// the sign and the overflow/div0 exception are applied in a final fix-up step.

module alu (
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  input  logic [4:0]  opcode,
  output logic [31:0] result
);
  // Opcode 1 subtracts; every other opcode adds.
  always_comb begin
    result = data_a + data_b;
    if (opcode == 5'b00001) result = data_a - data_b;
  end
endmodule

module alu_multdiv_seq #(
  parameter int unsigned ITERS   = 32,
  parameter logic [4:0]  OPC_ADD = 5'b00000,
  parameter logic [4:0]  OPC_SUB = 5'b00001
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t      state;
  logic        op_mult;
  logic        sign;
  logic        exc_pend;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] m;       // magnitude added (mult) or subtracted (div) each step
  logic [32:0] r;       // product high half / partial remainder
  logic [31:0] q;       // product low half / quotient
  logic [4:0]  cnt;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] rs;
  logic [31:0] alu_a;
  logic [4:0]  alu_op;
  logic [31:0] alu_y;
  logic [32:0] mul_acc;
  logic        ge;
  logic [63:0] sprod;
  logic [31:0] squot;
  logic        mul_ovf;

  alu u_alu (
    .data_a (alu_a),
    .data_b (m),
    .opcode (alu_op),
    .result (alu_y)
  );

  // Datapath helpers: magnitudes, alu operand select, carry/borrow, fix-up values.
  always_comb begin
    mag_a   = a_reg[31] ? (32'd0 - a_reg) : a_reg;
    mag_b   = b_reg[31] ? (32'd0 - b_reg) : b_reg;
    rs      = {r[31:0], q[31]};
    alu_a   = op_mult ? r[31:0] : rs[31:0];
    alu_op  = op_mult ? OPC_ADD : OPC_SUB;
    mul_acc = q[0] ? {(alu_y < r[31:0]), alu_y} : {1'b0, r[31:0]};
    ge      = rs[32] | (rs[31:0] >= m);
    sprod   = sign ? (64'd0 - {r[31:0], q}) : {r[31:0], q};
    squot   = sign ? (32'd0 - q) : q;
    mul_ovf = ~((sprod[63:31] == '0) | (sprod[63:31] == '1));
  end

  // Sequencer: start latch, prep, iterate, sign fix-up, completion pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      op_mult        <= 1'b0;
      sign           <= 1'b0;
      exc_pend       <= 1'b0;
      a_reg          <= '0;
      b_reg          <= '0;
      m              <= '0;
      r              <= '0;
      q              <= '0;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ctrl_MULT || ctrl_DIV) begin
            a_reg   <= data_operandA;
            b_reg   <= data_operandB;
            op_mult <= ctrl_MULT;
            busy    <= 1'b1;
            state   <= S_PREP;
          end
        end
        S_PREP: begin
          m        <= op_mult ? mag_a : mag_b;
          q        <= op_mult ? mag_b : mag_a;
          r        <= '0;
          sign     <= a_reg[31] ^ b_reg[31];
          exc_pend <= ~op_mult & ((b_reg == 32'd0) |
                      ((a_reg == 32'h8000_0000) & (b_reg == 32'hFFFF_FFFF)));
          cnt      <= '0;
          state    <= S_ITER;
        end
        S_ITER: begin
          if (op_mult) begin
            r <= {1'b0, mul_acc[32:1]};
            q <= {mul_acc[0], q[31:1]};
          end else begin
            r <= ge ? {1'b0, alu_y} : rs;
            q <= {q[30:0], ge};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'(ITERS - 1)) state <= S_FIX;
        end
        S_FIX: begin
          if (op_mult) begin
            data_result    <= sprod[31:0];
            data_exception <= mul_ovf;
          end else begin
            data_result    <= exc_pend ? 32'd0 : squot;
            data_exception <= exc_pend;
          end
          data_resultRDY <= 1'b1;
          state          <= S_DONE;
        end
        S_DONE: begin
          data_resultRDY <= 1'b0;
          busy           <= 1'b0;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_multdiv_seq.sv
// Self-checking bench for alu_multdiv_seq: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.

module tb_alu_multdiv_seq;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  alu_multdiv_seq dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Reference: {exception, result} from signed 64-bit arithmetic.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic mult);
    longint p;
    logic [31:0] qv;
    if (mult) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return {(p > 64'sd2147483647) || (p < -64'sd2147483648), p[31:0]};
    end
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'd0};
    qv = 32'($signed(a) / $signed(b));
    return {1'b0, qv};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 400)) - 32'd200;
      5: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Drive one start and collect completion data; leaves the bench in the first IDLE cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic mu,
                       input logic dv, output logic [31:0] res, output logic exc,
                       output int lat, output logic rdy_after, output logic busy_after);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = mu;
    ctrl_DIV = dv;
    @(posedge clock); #1;
    lat = 1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    while (!data_resultRDY && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    res = data_result;
    exc = data_exception;
    @(posedge clock); #1;
    rdy_after = data_resultRDY;
    busy_after = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if (data_result !== 32'd0) begin n_bad++; $display("FAIL reset_result got %h want 0", data_result); end
    n_cmp++; if (data_exception !== 1'b0) begin n_bad++; $display("FAIL reset_exc got %b want 0", data_exception); end
    n_cmp++; if (data_resultRDY !== 1'b0) begin n_bad++; $display("FAIL reset_rdy got %b want 0", data_resultRDY); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_directed();
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic        vm [8];
    logic [31:0] res;
    logic        exc, ra, ba;
    logic [32:0] exp;
    int          lat;
    va = '{32'd7, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FF9C, 32'd100, 32'h8000_0000, 32'd6, 32'hFFFF_FFFF};
    vb = '{32'hFFFF_FFFD, 32'd2, 32'd1, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF};
    vm = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      do_op(va[i], vb[i], vm[i], ~vm[i], res, exc, lat, ra, ba);
      exp = model(va[i], vb[i], vm[i]);
      n_cmp++; if (res !== exp[31:0]) begin n_bad++; $display("FAIL dir%0d_result got %h want %h", i, res, exp[31:0]); end
      n_cmp++; if (exc !== exp[32]) begin n_bad++; $display("FAIL dir%0d_exc got %b want %b", i, exc, exp[32]); end
      n_cmp++; if (lat != 35) begin n_bad++; $display("FAIL dir%0d_latency got %0d want 35", i, lat); end
      n_cmp++; if (ra !== 1'b0 || ba !== 1'b0) begin n_bad++; $display("FAIL dir%0d_pulse rdy=%b busy=%b want 0 0", i, ra, ba); end
    end
    // Result must hold through idle cycles.
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (data_result !== 32'd1) begin n_bad++; $display("FAIL hold_result got %h want 1", data_result); end
  endtask

  task automatic test_both_high();
    logic [31:0] res;
    logic        exc, ra, ba;
    int          lat;
    do_op(32'd6, 32'd3, 1'b1, 1'b1, res, exc, lat, ra, ba);
    n_cmp++; if (res !== 32'd18 || exc !== 1'b0) begin n_bad++; $display("FAIL both_high got %h/%b want 00000012/0", res, exc); end
  endtask

  task automatic test_ignored_starts();
    int pulses = 0;
    int busy_mid = 0;
    data_operandA = 32'd6;
    data_operandB = 32'd7;
    ctrl_MULT = 1'b1;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      data_operandA = 32'd100;
      data_operandB = 32'd0;
      ctrl_DIV = (c == 5 || c == 20);
      @(posedge clock); #1;
      if (data_resultRDY) pulses++;
      if (c == 10) busy_mid = int'(busy);
    end
    ctrl_DIV = 1'b0;
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL ignored_pulses got %0d want 1", pulses); end
    n_cmp++; if (data_result !== 32'd42 || data_exception !== 1'b0) begin n_bad++; $display("FAIL ignored_result got %h/%b want 0000002a/0", data_result, data_exception); end
    n_cmp++; if (busy_mid != 1 || busy !== 1'b0) begin n_bad++; $display("FAIL ignored_busy mid=%0d end=%b want 1 0", busy_mid, busy); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic        exc, ra, ba;
    int          lat;
    int          pulses = 0;
    data_operandA = 32'hFFFF_FF9C;
    data_operandB = 32'd7;
    ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    n_cmp++; if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid got %h/%b/%b/%b want all 0", data_result, data_exception, data_resultRDY, busy);
    end
    reset = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (data_resultRDY) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL reset_mid_rdy got %0d want 0", pulses); end
    do_op(32'd3, 32'd4, 1'b1, 1'b0, res, exc, lat, ra, ba);
    n_cmp++; if (res !== 32'd12 || exc !== 1'b0 || lat != 35) begin n_bad++; $display("FAIL after_reset got %h/%b lat %0d want 0000000c/0 35", res, exc, lat); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res;
    logic        mu, exc, ra, ba;
    logic [32:0] exp;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      a = pick();
      b = pick();
      mu = 1'($urandom_range(0, 1));
      do_op(a, b, mu, ~mu, res, exc, lat, ra, ba);
      exp = model(a, b, mu);
      n_cmp++; if (res !== exp[31:0] || exc !== exp[32]) begin
        n_bad++; $display("FAIL rand%0d %s a=%h b=%h got %h/%b want %h/%b", i, mu ? "mul" : "div", a, b, res, exc, exp[31:0], exp[32]);
      end
      n_cmp++; if (lat != 35) begin n_bad++; $display("FAIL rand%0d_latency got %0d want 35", i, lat); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_both_high();
    test_ignored_starts();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_multdiv_seq.md
Name: alu_multdiv_seq

Overview:
- Multicycle signed multiply/divide sequencer built around one internal alu instance.
- The alu instance performs the per-iteration 32-bit add or subtract; shift registers and control are local.
- Sits beside the main ALU in the execute stage. The pipeline pulses ctrl_MULT/ctrl_DIV once, stalls while busy, and takes the result on data_resultRDY.

Parameters:
- ITERS, 32, iteration count; must equal the 32-bit operand width, other values unsupported.
- OPC_ADD, 5'b00000, alu opcode driven during multiply iterations.
- OPC_SUB, 5'b00001, alu opcode driven during divide iterations.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- data_operandA  in  32  multiplicand / dividend, signed two's complement.
- data_operandB  in  32  multiplier / divisor, signed two's complement.
- ctrl_MULT  in  1  start multiply; sampled only in IDLE.
- ctrl_DIV  in  1  start divide; sampled only in IDLE.
- data_result  out  32  low 32 bits of product, or quotient.
- data_exception  out  1  overflow or divide-by-zero flag for the completed op.
- data_resultRDY  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after start through the DONE cycle.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE; data_result=0, data_exception=0, data_resultRDY=0, busy=0; internal registers cleared.
- Reset mid-operation: abort to IDLE on that edge; outputs cleared; no resultRDY pulse.
- Start rules:
  - In IDLE, a rising edge with ctrl_MULT=1 or ctrl_DIV=1 latches both operands and the op type, then enters PREP.
  - Both high: MULT wins.
  - Start pulses outside IDLE are ignored and are not queued.
- States: IDLE -> PREP (1 cycle) -> ITER (ITERS cycles) -> FIX (1 cycle) -> DONE (1 cycle) -> IDLE.
- Latency: start sampled at edge t; data_resultRDY high during the cycle after edge t+34, i.e. 35 cycles after start. Latency is fixed for every op, including exceptions.
- PREP:
  - Form magnitudes |A| and |B|, unsigned 32-bit; |0x80000000| = 0x80000000.
  - Record result sign = A31 ^ B31.
  - For DIV, flag div0 if B == 0.
- ITER, multiply (unsigned shift-add):
  - 64-bit product {hi, lo}; lo initialised to |B|, hi to 0.
  - Each cycle: if lo[0], hi += |A| via the alu with OPC_ADD; the alu carry-out is recomputed locally as bit 32.
  - Then shift {carry, hi, lo} right by 1.
- ITER, divide (restoring):
  - 33-bit partial remainder R, quotient Q initialised to |A|.
  - Each cycle: shift {R, Q} left 1, then trial = R - |B| (low 32 bits via the alu with OPC_SUB, borrow bit local).
  - If trial >= 0: R = trial and Q[0] = 1; else restore R and Q[0] = 0.
- FIX, multiply:
  - Apply the sign to the 64-bit product (two's complement if sign=1).
  - data_result = low 32 bits.
  - exception = 1 iff the signed 64-bit product is outside [-2^31, 2^31-1].
- FIX, divide:
  - quotient = sign ? -Q : Q, truncated toward zero; remainder discarded.
  - exception = 1 iff div0, or A = 0x80000000 with B = 0xFFFFFFFF.
  - On exception, data_result = 0.
- DONE: data_resultRDY=1 for exactly this cycle; data_result and data_exception are updated entering DONE.
- Output hold: data_result and data_exception hold their values until the next DONE or reset. busy deasserts entering IDLE.
- Back-to-back: a new start is accepted in the first IDLE cycle after DONE (start edge ending that cycle).
- Operand inputs may change freely after the start edge.

Test Plan:
- MULT A=7, B=-3 -> resultRDY exactly 35 cycles after start; result 0xFFFFFFEB, exception 0.
- MULT A=0x7FFFFFFF, B=2 -> result 0xFFFFFFFE, exception 1. MULT A=0x80000000, B=1 -> 0x80000000, exception 0.
- DIV A=-100, B=7 -> 0xFFFFFFF2 (-14), exception 0. DIV A=100, B=0 -> result 0, exception 1, same latency.
- DIV A=0x80000000, B=-1 -> result 0, exception 1.
- ctrl_DIV pulsed at cycles 5 and 20 during a MULT 6*7 -> one resultRDY, result 42, busy then low; the DIV pulses are ignored. ctrl_MULT and ctrl_DIV high together with A=6, B=3 -> result 18.
- reset asserted at cycle 10 of a DIV -> next edge all outputs 0 and state IDLE; no resultRDY; a following MULT 3*4 returns 12 after 35 cycles.
